// File: rtl/mux_4x1_8bits.sv
// Serializes four parallel lane bytes into a one-byte-per-clock stream, lane 0 first.
// Latency: lane j of a frame captured at edge E is on data_out after edge E+j; no backpressure, enable only gates frame starts.
module mux_4x1_8bits (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    input  logic [7:0] data_in3,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       valid_in2,
    input  logic       valid_in3,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] lane_sel,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [7:0]      fcnt_q, fcnt_d;
    logic [2:0][7:0] hold_dat_q, hold_dat_d;
    logic [2:0]      hold_vld_q, hold_vld_d;
    logic [7:0]      dout_q, dout_d;
    logic            vout_q, vout_d;
    logic            capture;
    logic [7:0]      held_dat;
    logic            held_vld;

    // hold slot k carries lane k+1
    always_comb begin
        held_dat = hold_dat_q[2];
        held_vld = hold_vld_q[2];
        case (cnt_q)
            2'd0:    begin held_dat = hold_dat_q[0]; held_vld = hold_vld_q[0]; end
            2'd1:    begin held_dat = hold_dat_q[1]; held_vld = hold_vld_q[1]; end
            default: begin held_dat = hold_dat_q[2]; held_vld = hold_vld_q[2]; end
        endcase
    end

    assign capture = enable && ((state_q == IDLE) || (cnt_q == 2'd3));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fcnt_d     = fcnt_q;
        hold_dat_d = hold_dat_q;
        hold_vld_d = hold_vld_q;
        dout_d     = dout_q;
        vout_d     = vout_q;
        if (capture) begin
            dout_d     = valid_in0 ? data_in0 : 8'h00;
            vout_d     = valid_in0;
            hold_dat_d = {data_in3, data_in2, data_in1};
            hold_vld_d = {valid_in3, valid_in2, valid_in1};
            cnt_d      = 2'd0;
            state_d    = RUN;
            fcnt_d     = fcnt_q + 8'd1;
        end else if ((state_q == RUN) && (cnt_q != 2'd3)) begin
            cnt_d  = cnt_q + 2'd1;
            dout_d = held_vld ? held_dat : 8'h00;
            vout_d = held_vld;
        end else begin
            state_d = IDLE;
            cnt_d   = 2'd0;
            dout_d  = 8'h00;
            vout_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            fcnt_q     <= 8'd0;
            hold_dat_q <= '0;
            hold_vld_q <= '0;
            dout_q     <= 8'h00;
            vout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fcnt_q     <= fcnt_d;
            hold_dat_q <= hold_dat_d;
            hold_vld_q <= hold_vld_d;
            dout_q     <= dout_d;
            vout_q     <= vout_d;
        end
    end

    assign data_out    = dout_q;
    assign valid_out   = vout_q;
    assign lane_sel    = (state_q == RUN) ? cnt_q : 2'd0;
    assign frame_start = (state_q == RUN) && (cnt_q == 2'd0);
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_mux_4x1_8bits.sv
// Bench for mux_4x1_8bits: directed and random steps checked against a slot-queue model of the framer.
module tb_mux_4x1_8bits;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] data_in0, data_in1, data_in2, data_in3;
    logic       valid_in0, valid_in1, valid_in2, valid_in3;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_sel;
    logic       frame_start;
    logic [7:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    // Model: slots still owed by the current frame, each {valid, byte}
    logic [8:0] slots[$];
    logic [7:0] exp_dat;
    logic       exp_vld;
    logic [1:0] exp_sel;
    logic       exp_fs;
    logic [7:0] exp_fcnt;

    mux_4x1_8bits dut (
        .clk(clk), .reset(reset), .enable(enable),
        .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
        .valid_in0(valid_in0), .valid_in1(valid_in1), .valid_in2(valid_in2), .valid_in3(valid_in3),
        .data_out(data_out), .valid_out(valid_out), .lane_sel(lane_sel),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".data_out"},    data_out,           exp_dat);
        chk({tag, ".valid_out"},   {7'd0, valid_out},   {7'd0, exp_vld});
        chk({tag, ".lane_sel"},    {6'd0, lane_sel},    {6'd0, exp_sel});
        chk({tag, ".frame_start"}, {7'd0, frame_start}, {7'd0, exp_fs});
        chk({tag, ".frame_cnt"},   frame_cnt,          exp_fcnt);
    endtask

    task automatic model_reset();
        slots.delete();
        exp_dat = 8'h00; exp_vld = 1'b0; exp_sel = 2'd0; exp_fs = 1'b0; exp_fcnt = 8'h00;
    endtask

    function automatic logic [8:0] slot(input logic v, input logic [7:0] d);
        return {v, v ? d : 8'h00};
    endfunction

    task automatic set_lanes(input logic [7:0] d0, d1, d2, d3, input logic [3:0] v);
        data_in0 = d0; data_in1 = d1; data_in2 = d2; data_in3 = d3;
        {valid_in3, valid_in2, valid_in1, valid_in0} = v;
    endtask

    task automatic rnd_lanes();
        set_lanes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
    endtask

    // One clock: inputs are stable across the edge, model advances, outputs checked 1 time unit later
    task automatic tick(input string tag);
        logic [8:0] s;
        logic       run;
        @(posedge clk);
        run = 1'b1;
        if (slots.size() != 0) begin
            s = slots.pop_front();
        end else if (enable) begin
            s = slot(valid_in0, data_in0);
            slots.push_back(slot(valid_in1, data_in1));
            slots.push_back(slot(valid_in2, data_in2));
            slots.push_back(slot(valid_in3, data_in3));
            exp_fcnt = exp_fcnt + 8'd1;
        end else begin
            s = 9'd0;
            run = 1'b0;
        end
        exp_dat = s[7:0];
        exp_vld = s[8];
        exp_sel = run ? 2'(3 - slots.size()) : 2'd0;
        exp_fs  = run && (slots.size() == 3);
        #1;
        chk_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        set_lanes(8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        model_reset();
        #3;
        chk_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // single frame, all lanes valid
        enable = 1'b1;
        set_lanes(8'hBC, 8'h1C, 8'h3C, 8'hF7, 4'hF);
        tick("single0");
        enable = 1'b0;
        rnd_lanes();
        for (int i = 0; i < 5; i++) tick("single");
        chk("single_fcnt", frame_cnt, 8'h01);

        // partial valids
        enable = 1'b1;
        set_lanes(8'h11, 8'h22, 8'h33, 8'h44, 4'b0101);
        tick("partial0");
        enable = 1'b0;
        for (int i = 0; i < 4; i++) tick("partial");

        // all-invalid frame still counts
        enable = 1'b1;
        set_lanes(8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'h0);
        tick("novalid0");
        enable = 1'b0;
        for (int i = 0; i < 4; i++) tick("novalid");

        // continuous streaming, inputs churn every cycle
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rnd_lanes();
            tick("stream");
        end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) tick("stream_end");

        // enable drops at cnt=1, then reasserts
        enable = 1'b1;
        rnd_lanes();
        tick("drop_cap");
        rnd_lanes();
        tick("drop_c1");
        enable = 1'b0;
        tick("drop_c2");
        tick("drop_c3");
        enable = 1'b1;
        rnd_lanes();
        tick("drop_idle");
        tick("drop_new");
        enable = 1'b0;
        for (int i = 0; i < 4; i++) tick("drop_tail");

        // asynchronous reset while cnt=2
        enable = 1'b1;
        rnd_lanes();
        tick("rst_cap");
        tick("rst_c1");
        tick("rst_c2");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk_all("rst_async");
        #1;
        reset = 1'b0;
        rnd_lanes();
        tick("rst_after");
        chk("rst_after_fcnt", frame_cnt, 8'h01);
        for (int i = 0; i < 3; i++) tick("rst_after_run");

        // random enable and data
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            rnd_lanes();
            tick("random");
        end

        // 256 frames from reset wrap frame_cnt back to zero
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        #1;
        reset = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            rnd_lanes();
            tick("wrap");
        end
        chk("wrap_fcnt", frame_cnt, 8'h00);
        for (int i = 0; i < 8; i++) begin
            rnd_lanes();
            tick("post_wrap");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_4x1_8bits.md
MUX_4X1_8BITS -- requirements
Module: mux_4x1_8bits

Interface
REQ-001 SHALL have clock `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have reset `reset`, input, 1 bit: asynchronous, active-high.
REQ-003 SHALL have `enable`, input, 1 bit: request to start or continue framing.
REQ-004 SHALL have `data_in0`..`data_in3`, input, 8 bits each: parallel lane bytes, lane 0 first on the wire.
REQ-005 SHALL have `valid_in0`..`valid_in3`, input, 1 bit each: per-lane byte-valid qualifiers.
REQ-006 SHALL have `data_out`, output, 8 bits: serialized byte stream (registered).
REQ-007 SHALL have `valid_out`, output, 1 bit: qualifier for `data_out` (registered).
REQ-008 SHALL have `lane_sel`, output, 2 bits: index of the lane currently on `data_out`.
REQ-009 SHALL have `frame_start`, output, 1 bit: high while lane 0 of a frame is on `data_out`.
REQ-010 SHALL have `frame_cnt`, output, 8 bits: number of frames captured, modulo 256.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and RUN, plus a 2-bit slot counter `cnt`.
REQ-012 Capture edge: a rising edge SHALL be a capture edge when either condition holds.
- State is IDLE and `enable`=1.
- State is RUN, `cnt`=3, and `enable`=1.
REQ-013 On a capture edge, the block SHALL do all of the following.
- `data_out`<=`data_in0` if `valid_in0`=1, else 8'h00.
- `valid_out`<=`valid_in0`.
- Load lanes 1..3 (data and valid) into holding registers.
- Set `cnt`<=0 and state<=RUN.
- Increment `frame_cnt`.
REQ-014 In RUN with `cnt`=k (k=0..2), the next edge SHALL set `cnt`<=k+1, present held lane k+1 on `data_out` and `valid_out`, and ignore all inputs.
REQ-015 A held lane whose captured valid=0 SHALL drive `data_out`=8'h00 and `valid_out`=0 in its slot.
REQ-016 Latency: lane j sampled at capture edge E SHALL appear on `data_out` in the cycle following edge E+j (j=0..3).
REQ-017 Back-to-back frames: with `enable` held at 1, frames SHALL abut with no gap, emitting one byte per clock.
REQ-018 `enable` deasserted mid-frame: the current frame SHALL complete all 4 slots.
- At the `cnt`=3 edge with `enable`=0, state SHALL go to IDLE.
- In that case `data_out`<=0, `valid_out`<=0, `cnt`<=0.
REQ-019 `enable` changes while `cnt`=0..2 SHALL have no effect until the `cnt`=3 edge.
REQ-020 In IDLE, outputs SHALL be held at: `data_out`=0, `valid_out`=0, `lane_sel`=0, `frame_start`=0.
REQ-021 `lane_sel` SHALL equal `cnt` in RUN, and 0 in IDLE.
REQ-022 `frame_start` SHALL be 1 only when state=RUN and `cnt`=0.
REQ-023 `frame_cnt` SHALL wrap from 8'hFF to 8'h00 with no flag.
REQ-024 Valid inputs SHALL NOT gate capture: a frame with all `valid_in`=0 is still captured, counted, and emitted as 4 slots of 8'h00 with `valid_out`=0.

Reset
REQ-025 `reset`=1 SHALL immediately, without waiting for `clk`, force the following.
- State=IDLE, `cnt`=0, `frame_cnt`=0.
- Holding registers=0.
- `data_out`=0, `valid_out`=0, `lane_sel`=0, `frame_start`=0.
REQ-026 Reset asserted mid-frame SHALL discard the remaining held lanes.
REQ-027 After `reset` deasserts, the first capture SHALL occur on the first rising edge with `enable`=1.

Verification
REQ-028 Single frame, all lanes valid.
- Stimulus: reset, then `enable`=1 for one edge with `data_in0..3`=8'hBC,8'h1C,8'h3C,8'hF7 and all valids=1, then `enable`=0.
- Response: `data_out`=BC,1C,3C,F7 on 4 consecutive cycles; `valid_out`=1; `lane_sel`=0,1,2,3; `frame_start` high on the first cycle only; then IDLE with zeros; `frame_cnt`=1.
REQ-029 Partial valids.
- Stimulus: `valid_in`=1,0,1,0 with data 8'h11,8'h22,8'h33,8'h44.
- Response: `data_out`=11,00,33,00 with `valid_out`=1,0,1,0.
REQ-030 Continuous streaming.
- Stimulus: `enable`=1 for 12 cycles with a new data set presented each `cnt`=3 cycle.
- Response: 12 contiguous bytes, no gaps; `frame_cnt`=3; inputs changed during `cnt`=0..2 do not appear on `data_out`.
REQ-031 Enable drop mid-frame.
- Stimulus: deassert `enable` at `cnt`=1.
- Response: lanes 2 and 3 are still emitted, then IDLE; reasserting `enable` starts a new frame with lane 0 one cycle later.
REQ-032 Reset mid-frame.
- Stimulus: assert `reset` between clock edges while `cnt`=2.
- Response: all outputs are 0 before the next edge; after release with `enable`=1, `frame_cnt`=1 and lane 0 is emitted.
REQ-033 Counter wrap.
- Stimulus: run 256 frames.
- Response: `frame_cnt` returns to 8'h00; streaming is unaffected.
